// File: rtl/sram_mem_controller.sv
// Sequences 32-bit loads/stores as two half-word accesses on a 16-bit async SRAM.
// Define SRAM_ADDR_CHECK_EN to reject out-of-range or misaligned addresses.
module sram_mem_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic               addr_err,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               isWrite_q, isWrite_d;
   logic [SRAM_AW-2:0] wordIdx_q, wordIdx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        readData_q, readData_d;
   logic [SRAM_AW-1:0] sramAddr_q, sramAddr_d;
   logic [15:0]        dqOut_q, dqOut_d;
   logic               dqOe_q, dqOe_d;
   logic               weN_q, weN_d;
   logic               oeN_q, oeN_d;
   logic               addrErr_q, addrErr_d;

   logic               req;
   logic [31:0]        idxFull;
   logic               lastCycle;
   logic               badAddr;
   logic               highHalf;
   logic               unusedBits;

   assign req       = rd_en | wr_en;
   assign idxFull   = (address - 32'(BASE_ADDR)) >> 2;
   assign lastCycle = (cnt_q == CW'(WAIT_CYCLES - 1));
   assign unusedBits = ^{idxFull[31:SRAM_AW-1], address[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
   assign badAddr = (address < 32'(BASE_ADDR)) || (address[1:0] != 2'b00) ||
                    (idxFull[31:SRAM_AW-1] != '0);
`else
   assign badAddr = 1'b0;
`endif

   // Strobes are computed from the state being entered, so the pins are registered
   // and change exactly on the cycle the controller enters LOW/HIGH.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      isWrite_d  = isWrite_q;
      wordIdx_d  = wordIdx_q;
      wdata_d    = wdata_q;
      readData_d = readData_q;
      sramAddr_d = sramAddr_q;
      dqOut_d    = dqOut_q;
      dqOe_d     = 1'b0;
      weN_d      = 1'b1;
      oeN_d      = 1'b1;
      addrErr_d  = 1'b0;
      highHalf   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (badAddr) begin
                  state_d   = DONE;
                  addrErr_d = 1'b1;
               end else begin
                  state_d   = LOW;
                  cnt_d     = '0;
                  isWrite_d = wr_en;
                  wordIdx_d = idxFull[SRAM_AW-2:0];
                  wdata_d   = write_data;
               end
            end
         end
         LOW: begin
            if (lastCycle) begin
               if (!isWrite_q) readData_d[15:0] = sram_dq_in;
               state_d = HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HIGH: begin
            if (lastCycle) begin
               if (!isWrite_q) readData_d[31:16] = sram_dq_in;
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == LOW || state_d == HIGH) begin
         highHalf   = (state_d == HIGH);
         sramAddr_d = {wordIdx_d, highHalf};
         if (isWrite_d) begin
            dqOut_d = highHalf ? wdata_d[31:16] : wdata_d[15:0];
            dqOe_d  = 1'b1;
            weN_d   = 1'b0;
         end else begin
            oeN_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         isWrite_q  <= 1'b0;
         wordIdx_q  <= '0;
         wdata_q    <= '0;
         readData_q <= '0;
         sramAddr_q <= '0;
         dqOut_q    <= '0;
         dqOe_q     <= 1'b0;
         weN_q      <= 1'b1;
         oeN_q      <= 1'b1;
         addrErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         isWrite_q  <= isWrite_d;
         wordIdx_q  <= wordIdx_d;
         wdata_q    <= wdata_d;
         readData_q <= readData_d;
         sramAddr_q <= sramAddr_d;
         dqOut_q    <= dqOut_d;
         dqOe_q     <= dqOe_d;
         weN_q      <= weN_d;
         oeN_q      <= oeN_d;
         addrErr_q  <= addrErr_d;
      end
   end

   assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
   assign read_data   = readData_q;
   assign addr_err    = addrErr_q;
   assign sram_addr   = sramAddr_q;
   assign sram_dq_out = dqOut_q;
   assign sram_dq_oe  = dqOe_q;
   assign sram_we_n   = weN_q;
   assign sram_oe_n   = oeN_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed and random loads/stores against a word-level model.
// Build with SRAM_ADDR_CHECK_EN defined to exercise the address-check path.
module tb_sram_mem_controller;

   localparam int BASE_ADDR   = 1024;
   localparam int WAIT_CYCLES = 2;
   localparam int SRAM_AW     = 18;
   localparam int NUM_WORDS   = 2 ** (SRAM_AW - 1);

   logic               clk = 1'b0;
   logic               rst;
   logic               rd_en, wr_en;
   logic [31:0]        address, write_data;
   logic [31:0]        read_data;
   logic               ready, addr_err;
   logic [SRAM_AW-1:0] sram_addr;
   logic [15:0]        sram_dq_out, sram_dq_in;
   logic               sram_dq_oe, sram_we_n, sram_oe_n;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] sramMem [0:2**SRAM_AW-1];
   logic [31:0] refMem [int];
   logic [31:0] lastRead;

   sram_mem_controller #(
      .BASE_ADDR  (BASE_ADDR),
      .WAIT_CYCLES(WAIT_CYCLES),
      .SRAM_AW    (SRAM_AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .addr_err   (addr_err),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_in (sram_dq_in),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: reads are combinational under oe_n, writes land while we_n is low.
   assign sram_dq_in = (!sram_oe_n) ? sramMem[sram_addr] : 16'hA5A5;

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) sramMem[sram_addr] <= sram_dq_out;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic idleCycle();
      rd_en = 1'b0;
      wr_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Runs one request from an IDLE cycle through DONE, checking the pin timeline each
   // cycle, then steps one more cycle so the controller is back in IDLE.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data);
      logic               isWr;
      logic               bad;
      logic               hi;
      int                 idx;
      logic [31:0]        expRead;
      logic [SRAM_AW-1:0] expAddr;

      isWr = wr;
      idx  = int'(((addr - BASE_ADDR) >> 2) % NUM_WORDS);
      bad  = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
      bad = (addr < BASE_ADDR) || (addr[1:0] != 2'b00) || (((addr - BASE_ADDR) >> 2) >= NUM_WORDS);
`endif
      expRead = lastRead;
      if (!bad && !isWr) expRead = refMem.exists(idx) ? refMem[idx] : 32'h0;
      if (!bad && isWr) refMem[idx] = data;

      rd_en      = rd;
      wr_en      = wr;
      address    = addr;
      write_data = data;
      #1;
      checkOutput("ready_on_request", ready, 0);

      if (bad) begin
         @(posedge clk);
         #1;
         checkOutput("err_ready", ready, 1);
         checkOutput("err_flag", addr_err, 1);
         checkOutput("err_oe_n", sram_oe_n, 1);
         checkOutput("err_we_n", sram_we_n, 1);
         checkOutput("err_read_data", read_data, expRead);
      end else begin
         for (int k = 1; k <= 2 * WAIT_CYCLES; k++) begin
            @(posedge clk);
            #1;
            hi      = (k > WAIT_CYCLES);
            expAddr = SRAM_AW'(idx * 2 + (hi ? 1 : 0));
            checkOutput("busy_ready", ready, 0);
            checkOutput("busy_addr", sram_addr, expAddr);
            checkOutput("busy_we_n", sram_we_n, isWr ? 0 : 1);
            checkOutput("busy_oe_n", sram_oe_n, isWr ? 1 : 0);
            checkOutput("busy_dq_oe", sram_dq_oe, isWr);
            checkOutput("busy_addr_err", addr_err, 0);
            if (isWr) checkOutput("busy_dq_out", sram_dq_out, hi ? data[31:16] : data[15:0]);
         end
         @(posedge clk);
         #1;
         checkOutput("done_ready", ready, 1);
         checkOutput("done_we_n", sram_we_n, 1);
         checkOutput("done_oe_n", sram_oe_n, 1);
         checkOutput("done_dq_oe", sram_dq_oe, 0);
         checkOutput("done_addr_err", addr_err, 0);
         checkOutput("done_read_data", read_data, expRead);
      end
      lastRead = expRead;
      @(posedge clk);
      #1;
   endtask

   initial begin
      $display("[TB] start");
      for (int i = 0; i < 2 ** SRAM_AW; i++) sramMem[i] = 16'h0;
      lastRead   = 32'h0;
      rst        = 1'b0;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      address    = 32'h0;
      write_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_read_data", read_data, 0);
      checkOutput("rst_sram_addr", sram_addr, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_ready", ready, 1);
      checkOutput("idle_we_n", sram_we_n, 1);
      checkOutput("idle_oe_n", sram_oe_n, 1);
      checkOutput("idle_dq_oe", sram_dq_oe, 0);
      checkOutput("idle_read_data", read_data, 0);
      checkOutput("idle_addr_err", addr_err, 0);

      $display("[TB] directed store/load at 1024");
      applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
      idleCycle();

      $display("[TB] back-to-back store/load at 1032");
      applyStimulus(1'b0, 1'b1, 32'd1032, 32'h12345678);
      applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
      idleCycle();

      $display("[TB] both enables asserted is a write");
      applyStimulus(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
      applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0);
      idleCycle();

      $display("[TB] out-of-range and misaligned addresses");
      applyStimulus(1'b1, 1'b0, 32'd1000, 32'h0);
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'd1026, 32'h0);
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'(BASE_ADDR + 4 * NUM_WORDS), 32'h0);
      idleCycle();

      $display("[TB] reset during high half of a store");
      wr_en      = 1'b1;
      address    = 32'(BASE_ADDR + 4 * 100);
      write_data = 32'h55AA33CC;
      repeat (WAIT_CYCLES + 1) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort_in_high", sram_addr, 201);
      rst = 1'b0;
      #1;
      checkOutput("abort_we_n", sram_we_n, 1);
      checkOutput("abort_oe_n", sram_oe_n, 1);
      checkOutput("abort_dq_oe", sram_dq_oe, 0);
      checkOutput("abort_sram_addr", sram_addr, 0);
      checkOutput("abort_dq_out", sram_dq_out, 0);
      checkOutput("abort_read_data", read_data, 0);
      checkOutput("abort_addr_err", addr_err, 0);
      wr_en = 1'b0;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_abort_ready", ready, 1);
      checkOutput("post_abort_we_n", sram_we_n, 1);
      checkOutput("post_abort_oe_n", sram_oe_n, 1);
      checkOutput("post_abort_dq_oe", sram_dq_oe, 0);
      lastRead = 32'h0;

      $display("[TB] random loads/stores");
      for (int n = 0; n < 40; n++) begin
         int unsigned w;
         w = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1)
            applyStimulus(1'b0, 1'b1, 32'(BASE_ADDR) + 32'(w * 4), $urandom);
         else
            applyStimulus(1'b1, 1'b0, 32'(BASE_ADDR) + 32'(w * 4), 32'h0);
         if ($urandom_range(0, 2) == 0) idleCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
